lx32_branch_resolve_bht: RTL and testbench

Branch resolution unit with a built-in direct-mapped branch history table (BHT) of 2-bit saturating counters. It sits between fetch and execute. Fetch reads a taken/not-taken prediction combinationally by PC. Execute presents operands and the predicted direction, and one cycle later receives the registered outcome and a mispredict flag, while the BHT is trained at that same edge.

---
 rtl/lx32_branch_pkg.sv | 35 +++
 rtl/lx32_bht.sv | 34 +++
 rtl/lx32_branch_resolve_bht.sv | 105 ++++++++++
 tb/tb_lx32_branch_resolve_bht.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lx32_branch_pkg.sv
// Shared types for the lx32 branch resolution unit: comparison ops,
// BHT counter states and the saturating counter step function.
package lx32_branch_pkg;

   typedef enum logic [2:0] {
      BR_EQ  = 3'd0,
      BR_NE  = 3'd1,
      BR_LT  = 3'd2,
      BR_GE  = 3'd3,
      BR_LTU = 3'd4,
      BR_GEU = 3'd5
   } branch_op_e;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bht_state_e;

   localparam bht_state_e BHT_INIT = WNT;

   // Saturating two-bit counter step; the MSB of the result is the prediction.
   function automatic bht_state_e bht_next(input bht_state_e cur, input logic taken);
      bht_state_e nxt;
      nxt = cur;
      if (taken) begin
         if (cur != ST) nxt = bht_state_e'(cur + 2'd1);
      end else begin
         if (cur != SNT) nxt = bht_state_e'(cur - 2'd1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/lx32_bht.sv
// Direct-mapped array of 2-bit saturating counters with a combinational
// read port and a single update port; reset loads every entry with WNT.
module lx32_bht
   import lx32_branch_pkg::*;
#(
   parameter int ENTRIES = 64,
   localparam int IDX_W = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx,
   output bht_state_e       rd_state,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_taken
);

   bht_state_e bht [ENTRIES];

   // Reset has priority over any update presented in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            bht[i] <= BHT_INIT;
         end
      end else if (wr_en) begin
         bht[wr_idx] <= bht_next(bht[wr_idx], wr_taken);
      end
   end

   // Reads see the pre-update value when the same entry is written this cycle.
   assign rd_state = bht[rd_idx];

endmodule

// File: rtl/lx32_branch_resolve_bht.sv
// Branch resolution with a built-in BHT predictor.
// Define LX32_BHT_STATS_EN to add branch/mispredict statistics counters.
module lx32_branch_resolve_bht
   import lx32_branch_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int PC_LSB      = 2
`ifdef LX32_BHT_STATS_EN
   ,
   parameter int STAT_W      = 32
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] pred_pc,
   output logic             pred_taken,
   input  logic             ex_valid,
   input  logic             ex_is_branch,
   input  branch_op_e       ex_branch_op,
   input  logic [WIDTH-1:0] ex_src_a,
   input  logic [WIDTH-1:0] ex_src_b,
   input  logic [WIDTH-1:0] ex_pc,
   input  logic             ex_pred_taken,
   input  logic             ex_flush,
   output logic             res_valid,
   output logic             res_taken,
   output logic             res_mispredict
`ifdef LX32_BHT_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_branches,
   output logic [STAT_W-1:0] stat_mispredicts
`endif
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   logic             fire;
   logic             cmp_taken;
   logic             mispredict;
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] wr_idx;
   bht_state_e       rd_state;
   logic             unused_bits;

   assign fire       = ex_valid & ex_is_branch & ~ex_flush;
   assign mispredict = cmp_taken ^ ex_pred_taken;
   assign rd_idx     = pred_pc[PC_LSB +: IDX_W];
   assign wr_idx     = ex_pc[PC_LSB +: IDX_W];
   assign pred_taken = rd_state[1];

   // PC bits outside the index are intentionally ignored (aliasing is allowed).
   assign unused_bits = ^{pred_pc, ex_pc, rd_state[0]};

   always_comb begin
      cmp_taken = 1'b0;
      case (ex_branch_op)
         BR_EQ:   cmp_taken = (ex_src_a == ex_src_b);
         BR_NE:   cmp_taken = (ex_src_a != ex_src_b);
         BR_LT:   cmp_taken = ($signed(ex_src_a) <  $signed(ex_src_b));
         BR_GE:   cmp_taken = ($signed(ex_src_a) >= $signed(ex_src_b));
         BR_LTU:  cmp_taken = (ex_src_a <  ex_src_b);
         BR_GEU:  cmp_taken = (ex_src_a >= ex_src_b);
         default: cmp_taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_valid      <= 1'b0;
         res_taken      <= 1'b0;
         res_mispredict <= 1'b0;
      end else begin
         res_valid      <= fire;
         res_taken      <= fire & cmp_taken;
         res_mispredict <= fire & mispredict;
      end
   end

   lx32_bht #(
      .ENTRIES (BHT_ENTRIES)
   ) u_bht (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_idx   (rd_idx),
      .rd_state (rd_state),
      .wr_en    (fire),
      .wr_idx   (wr_idx),
      .wr_taken (cmp_taken)
   );

`ifdef LX32_BHT_STATS_EN
   // Counters wrap naturally at 2^STAT_W.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else if (fire) begin
         stat_branches <= stat_branches + 1'b1;
         if (mispredict) stat_mispredicts <= stat_mispredicts + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_lx32_branch_resolve_bht.sv
// Self-checking bench for lx32_branch_resolve_bht: vector table for the
// comparator plus directed sequences for BHT training, flush, reset and stats.
module tb_lx32_branch_resolve_bht;
   import lx32_branch_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pred_pc;
   logic        pred_taken;
   logic        ex_valid;
   logic        ex_is_branch;
   branch_op_e  ex_branch_op;
   logic [31:0] ex_src_a;
   logic [31:0] ex_src_b;
   logic [31:0] ex_pc;
   logic        ex_pred_taken;
   logic        ex_flush;
   logic        res_valid;
   logic        res_taken;
   logic        res_mispredict;
`ifdef LX32_BHT_STATS_EN
   logic [3:0]  stat_branches;
   logic [3:0]  stat_mispredicts;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lx32_branch_resolve_bht #(
      .WIDTH       (32),
      .BHT_ENTRIES (64),
      .PC_LSB      (2)
`ifdef LX32_BHT_STATS_EN
      ,
      .STAT_W      (4)
`endif
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pred_pc        (pred_pc),
      .pred_taken     (pred_taken),
      .ex_valid       (ex_valid),
      .ex_is_branch   (ex_is_branch),
      .ex_branch_op   (ex_branch_op),
      .ex_src_a       (ex_src_a),
      .ex_src_b       (ex_src_b),
      .ex_pc          (ex_pc),
      .ex_pred_taken  (ex_pred_taken),
      .ex_flush       (ex_flush),
      .res_valid      (res_valid),
      .res_taken      (res_taken),
      .res_mispredict (res_mispredict)
`ifdef LX32_BHT_STATS_EN
      ,
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
`endif
   );

   typedef struct {
      branch_op_e  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        pred;
      logic        exp_taken;
      logic        exp_misp;
   } vec_t;

   vec_t vecs [11];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic valid, input logic is_br, input logic flush,
                                 input branch_op_e op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] pc,
                                 input logic pred);
      ex_valid      = valid;
      ex_is_branch  = is_br;
      ex_flush      = flush;
      ex_branch_op  = op;
      ex_src_a      = a;
      ex_src_b      = b;
      ex_pc         = pc;
      ex_pred_taken = pred;
   endtask

   task automatic idle();
      apply_stimulus(1'b0, 1'b0, 1'b0, BR_EQ, 32'd0, 32'd0, 32'd0, 1'b0);
   endtask

   // Taken/not-taken branch at a given PC using BR_EQ / BR_NE on equal operands.
   task automatic fire_dir(input logic [31:0] pc, input logic taken, input logic pred);
      apply_stimulus(1'b1, 1'b1, 1'b0, taken ? BR_EQ : BR_NE, 32'd1, 32'd1, pc, pred);
   endtask

   task automatic check_pred(input string name, input logic [31:0] pc, input logic exp);
      pred_pc = pc;
      #1;
      check_output(name, {31'd0, pred_taken}, {31'd0, exp});
   endtask

   initial begin
      vecs[0]  = '{BR_LT,  32'hFFFF_FFFF, 32'd1,          1'b0, 1'b1, 1'b1};
      vecs[1]  = '{BR_LTU, 32'hFFFF_FFFF, 32'd1,          1'b0, 1'b0, 1'b0};
      vecs[2]  = '{BR_GEU, 32'd5,         32'd5,          1'b1, 1'b1, 1'b0};
      vecs[3]  = '{BR_EQ,  32'd7,         32'd7,          1'b0, 1'b1, 1'b1};
      vecs[4]  = '{BR_EQ,  32'd7,         32'd7,          1'b1, 1'b1, 1'b0};
      vecs[5]  = '{BR_NE,  32'd7,         32'd7,          1'b1, 1'b0, 1'b1};
      vecs[6]  = '{BR_GE,  32'h8000_0000, 32'd0,          1'b0, 1'b0, 1'b0};
      vecs[7]  = '{BR_GEU, 32'h8000_0000, 32'd0,          1'b0, 1'b1, 1'b1};
      vecs[8]  = '{BR_LT,  32'd3,         32'h7FFF_FFFF,  1'b1, 1'b1, 1'b0};
      vecs[9]  = '{branch_op_e'(3'd6), 32'd1, 32'd1,      1'b1, 1'b0, 1'b1};
      vecs[10] = '{branch_op_e'(3'd7), 32'd0, 32'd0,      1'b0, 1'b0, 1'b0};

      rst_n   = 1'b0;
      pred_pc = 32'd0;
      idle();
      step();
      step();
      check_output("reset res_valid", {31'd0, res_valid}, 32'd0);
      check_output("reset res_taken", {31'd0, res_taken}, 32'd0);
      check_output("reset res_mispredict", {31'd0, res_mispredict}, 32'd0);
`ifdef LX32_BHT_STATS_EN
      check_output("reset stat_branches", {28'd0, stat_branches}, 32'd0);
      check_output("reset stat_mispredicts", {28'd0, stat_mispredicts}, 32'd0);
`endif
      rst_n = 1'b1;
      step();
      for (int i = 0; i < 64; i++) begin
         check_pred($sformatf("reset pred idx%0d", i), 32'(i) << 2, 1'b0);
      end
      check_output("idle res_valid", {31'd0, res_valid}, 32'd0);

      // Comparator vectors, back to back, one fire per cycle.
      for (int i = 0; i < 11; i++) begin
         apply_stimulus(1'b1, 1'b1, 1'b0, vecs[i].op, vecs[i].a, vecs[i].b,
                        32'h1000, vecs[i].pred);
         step();
         check_output($sformatf("vec%0d res_valid", i), {31'd0, res_valid}, 32'd1);
         check_output($sformatf("vec%0d res_taken", i), {31'd0, res_taken}, {31'd0, vecs[i].exp_taken});
         check_output($sformatf("vec%0d res_mispredict", i), {31'd0, res_mispredict}, {31'd0, vecs[i].exp_misp});
      end
      idle();
      step();
      check_output("after vecs res_valid", {31'd0, res_valid}, 32'd0);
      check_output("after vecs res_taken", {31'd0, res_taken}, 32'd0);

      // Train idx 16 to ST, then reset while a taken fire is presented.
      fire_dir(32'h40, 1'b1, 1'b0);
      step();
      check_pred("idx16 after 1 taken", 32'h40, 1'b1);
      fire_dir(32'h40, 1'b1, 1'b1);
      step();
      fire_dir(32'h40, 1'b1, 1'b1);
      rst_n = 1'b0;
      step();
      check_output("mid reset res_valid", {31'd0, res_valid}, 32'd0);
      check_pred("mid reset idx16", 32'h40, 1'b0);
      rst_n = 1'b1;
      idle();
      step();
      check_pred("mid reset idx16 held", 32'h40, 1'b0);
      check_pred("mid reset idx0", 32'h1000, 1'b0);

      // Saturation at 0x100 (idx 0, WNT after reset).
      fire_dir(32'h100, 1'b1, 1'b0);
      step();
      check_pred("sat 1st taken", 32'h100, 1'b1);
      fire_dir(32'h100, 1'b1, 1'b1);
      step();
      check_pred("sat 2nd taken", 32'h100, 1'b1);
      fire_dir(32'h100, 1'b1, 1'b1);
      step();
      check_pred("sat 3rd taken", 32'h100, 1'b1);
      check_pred("alias 0x200", 32'h200, 1'b1);
      fire_dir(32'h100, 1'b0, 1'b1);
      step();
      check_output("sat nt mispredict", {31'd0, res_mispredict}, 32'd1);
      check_pred("sat after 1 nt", 32'h100, 1'b1);
      fire_dir(32'h100, 1'b0, 1'b1);
      step();
      check_pred("sat after 2 nt", 32'h100, 1'b0);

      // Flushed and non-branch instructions neither resolve nor train.
      apply_stimulus(1'b1, 1'b1, 1'b1, BR_EQ, 32'd1, 32'd1, 32'h100, 1'b0);
      step();
      check_output("flush res_valid", {31'd0, res_valid}, 32'd0);
      check_pred("flush no train", 32'h100, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b0, BR_EQ, 32'd1, 32'd1, 32'h100, 1'b0);
      step();
      check_output("nonbranch res_valid", {31'd0, res_valid}, 32'd0);
      check_pred("nonbranch no train", 32'h100, 1'b0);
      apply_stimulus(1'b0, 1'b1, 1'b0, BR_EQ, 32'd1, 32'd1, 32'h100, 1'b0);
      step();
      check_output("invalid res_valid", {31'd0, res_valid}, 32'd0);
      check_pred("invalid no train", 32'h100, 1'b0);

      // Read-during-write on idx 4.
      fire_dir(32'h10, 1'b1, 1'b0);
      check_pred("rdw old value", 32'h10, 1'b0);
      step();
      check_pred("rdw new value", 32'h10, 1'b1);
      fire_dir(32'h10, 1'b0, 1'b1);
      check_pred("rdw old value 2", 32'h10, 1'b1);
      step();
      check_pred("rdw new value 2", 32'h10, 1'b0);
      idle();
      step();

`ifdef LX32_BHT_STATS_EN
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         fire_dir(32'h80, 1'b1, (i % 3 == 0 && i < 9) ? 1'b0 : 1'b1);
         step();
      end
      idle();
      step();
      check_output("stat_branches 10", {28'd0, stat_branches}, 32'd10);
      check_output("stat_mispredicts 3", {28'd0, stat_mispredicts}, 32'd3);
      for (int i = 0; i < 7; i++) begin
         fire_dir(32'h80, 1'b1, 1'b1);
         step();
      end
      idle();
      step();
      check_output("stat_branches wrap", {28'd0, stat_branches}, 32'd1);
      check_output("stat_mispredicts hold", {28'd0, stat_mispredicts}, 32'd3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
